// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 8:1 select arbiter: requester count,
// select width and FSM state encoding.
package mux_rr_arbiter_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux8_sel.sv
// Combinational 8:1 single-bit select; forms the D input of the arbiter's data register.
module mux8_sel
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  din_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             bit_o
);

  assign bit_o = din_i[sel_i];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select lines of an 8:1 bit datapath.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  din,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             y
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  // First requester found scanning last+1 .. last+8 (mod 8); last itself is lowest priority.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             y_q, y_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] pick_w;
  logic             sel_bit;
  logic             timeout;

  assign pick_w = rr_pick(req, last_q);

  mux8_sel u_mux8_sel (
    .din_i (din),
    .sel_i (sel_q),
    .bit_o (sel_bit)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;

  assign timeout = (hold_cnt_q == HoldLast);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == StIdle) begin
      if (|req) hold_cnt_d = '0;
    end else if (hold_cnt_q != HoldLast) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    y_d     = y_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          sel_d   = pick_w;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_w;
          busy_d  = 1'b1;
          last_d  = pick_w;
          state_d = StGrant;
        end
      end
      StGrant: begin
        y_d = sel_bit;
        // Release wins over the data capture: y returns to 0 on the release edge.
        if (!req[sel_q] || timeout) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          y_d     = 1'b0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      y_q     <= 1'b0;
      last_q  <= SEL_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      y_q     <= y_d;
      last_q  <= last_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign y    = y_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter; expected output snapshots are queued per cycle.
module tb_mux_rr_arbiter;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       y;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       y;

  obs_t obs;
  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  assign obs = {sel, gnt, busy, y};

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .sel   (sel),
    .gnt   (gnt),
    .busy  (busy),
    .y     (y)
  );

  function automatic obs_t mk(input logic [2:0] s, input logic [7:0] g, input logic b,
                              input logic yv);
    return {s, g, b, yv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    din   = 8'h00;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    req   = 8'h00;
    din   = 8'h00;
    #3;
    exp_q.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0));
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", obs, e);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_idle[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_pair_priority();
    logic [7:0] reqs[6];
    obs_t       exps[6];
    obs_t       e;
    reqs = '{8'h81, 8'h81, 8'h80, 8'h80, 8'h00, 8'h00};
    exps = '{mk(3'd0, 8'h01, 1'b1, 1'b0), mk(3'd0, 8'h01, 1'b1, 1'b0),
             mk(3'd0, 8'h00, 1'b0, 1'b0), mk(3'd7, 8'h80, 1'b1, 1'b0),
             mk(3'd7, 8'h00, 1'b0, 1'b0), mk(3'd7, 8'h00, 1'b0, 1'b0)};
    for (int i = 0; i < 6; i++) begin
      req = reqs[i];
      exp_q.push_back(exps[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL pair_priority[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_rotation();
    obs_t       e;
    logic [2:0] w;
    logic [7:0] onehot;
    for (int g = 0; g < 9; g++) begin
      w      = 3'(g % 8);
      onehot = 8'h01 << w;
      req    = 8'hFF;
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back(mk(w, onehot, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL rotation_grant[%0d.%0d] got=%b exp=%b", g, c, obs, e);
        end
      end
      req = (g == 8) ? 8'h00 : (8'hFF & ~onehot);
      exp_q.push_back(mk(w, 8'h00, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rotation_release[%0d] got=%b exp=%b", g, obs, e);
      end
    end
  endtask

  task automatic test_data_path();
    logic [7:0] dvals[6];
    logic       yexp[6];
    obs_t       e;
    dvals = '{8'b0000_0100, 8'hFB, 8'h04, 8'hFF, 8'h00, 8'hA4};
    yexp  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    req = 8'h04;
    din = 8'h00;
    exp_q.push_back(mk(3'd2, 8'h04, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL data_grant got=%b exp=%b", obs, e);
    end
    for (int i = 0; i < 6; i++) begin
      din = dvals[i];
      exp_q.push_back(mk(3'd2, 8'h04, 1'b1, yexp[i]));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL data_follow[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    req = 8'h00;
    din = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(3'd2, 8'h00, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL data_release[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    obs_t exps[11];
    obs_t e;
    apply_reset();
    exps = '{mk(3'd0, 8'h01, 1'b1, 1'b0), mk(3'd0, 8'h01, 1'b1, 1'b0),
             mk(3'd0, 8'h01, 1'b1, 1'b0), mk(3'd0, 8'h01, 1'b1, 1'b0),
             mk(3'd0, 8'h00, 1'b0, 1'b0),
             mk(3'd3, 8'h08, 1'b1, 1'b0), mk(3'd3, 8'h08, 1'b1, 1'b0),
             mk(3'd3, 8'h08, 1'b1, 1'b0), mk(3'd3, 8'h08, 1'b1, 1'b0),
             mk(3'd3, 8'h00, 1'b0, 1'b0),
             mk(3'd0, 8'h01, 1'b1, 1'b0)};
    req = 8'h09;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(exps[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL timeout[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    req = 8'h00;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    obs_t e;
    apply_reset();
    req = 8'h09;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(mk(3'd0, 8'h01, 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL long_hold[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    req = 8'h08;
    exp_q.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0));
    exp_q.push_back(mk(3'd3, 8'h08, 1'b1, 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL long_hold_next[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    req = 8'h00;
    tick();
  endtask
`endif

  task automatic test_reset_mid_grant();
    obs_t e;
    apply_reset();
    req = 8'h20;
    din = 8'hFF;
    exp_q.push_back(mk(3'd5, 8'h20, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd5, 8'h20, 1'b1, 1'b1));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL midrst_grant[%0d] got=%b exp=%b", i, obs, e);
      end
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL midrst_async got=%b exp=%b", obs, e);
    end
    req = 8'hFF;
    tick();
    rst_n = 1'b1;
    exp_q.push_back(mk(3'd0, 8'h01, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd0, 8'h01, 1'b1, 1'b1));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL midrst_regrant[%0d] got=%b exp=%b", i, obs, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pair_priority();
    test_rotation();
    test_data_path();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
